// File: rtl/tb_cpu_pkg.sv
// Shared constants and types for the miniTB CPU write-back path.
// Phase encodings, default widths and the write-back request record.
package tb_cpu_pkg;

    localparam logic [2:0] PH_T0 = 3'd0;
    localparam logic [2:0] PH_T1 = 3'd1;
    localparam logic [2:0] PH_T2 = 3'd2;
    localparam logic [2:0] PH_T3 = 3'd3;
    localparam logic [2:0] PH_X0 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam int WB_DATA_W      = 4;
    localparam int WB_NUM_REGS    = 3;
    localparam int WB_WRITE_CYCLE = int'(PH_X2);

    localparam logic [0:0] BUF_EMPTY = 1'b0;
    localparam logic [0:0] BUF_HELD  = 1'b1;

    // Default-width view of a request; the RTL carries the same fields flattened.
    typedef struct packed {
        logic [WB_DATA_W-1:0]   data;
        logic [WB_NUM_REGS-1:0] en;
        logic                   flag_en;
        logic                   flag;
    } wb_req_t;

endpackage

// File: rtl/tb_wb_buffer.sv
// Single-entry valid/ready holding register for write-back requests.
// Releases a request only in the write phase; passes through when empty.
module tb_wb_buffer
    import tb_cpu_pkg::*;
#(
    parameter int REQ_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             do_write,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REQ_W-1:0] in_req,
    output logic             commit,
    output logic [REQ_W-1:0] commit_req,
    output logic             pending
);

    logic [0:0]       state_q, state_d;
    logic [REQ_W-1:0] buf_q, buf_d;
    logic             accept;

    // The held slot frees in the commit cycle, so a new request can enter behind it.
    assign in_ready = (state_q == BUF_EMPTY) || do_write;
    assign accept   = in_valid && in_ready;
    assign pending  = (state_q == BUF_HELD);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        commit     = 1'b0;
        commit_req = buf_q;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    if (do_write) begin
                        commit     = 1'b1;
                        commit_req = in_req;
                    end else begin
                        state_d = BUF_HELD;
                        buf_d   = in_req;
                    end
                end
            end
            default: begin
                if (do_write) begin
                    commit     = 1'b1;
                    commit_req = buf_q;
                    if (accept) begin
                        buf_d = in_req;
                    end else begin
                        state_d = BUF_EMPTY;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Contents are meaningless while EMPTY, so the data slot needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: rtl/tb_wb_regfile.sv
// Parametrised register write-back unit: register array, carry flag,
// bypassed read port, sticky conflict flag and a wrapping commit counter.
module tb_wb_regfile
    import tb_cpu_pkg::*;
#(
    parameter int DATA_W      = WB_DATA_W,
    parameter int NUM_REGS    = WB_NUM_REGS,
    parameter int CYCLE_W     = 3,
    parameter int WRITE_CYCLE = WB_WRITE_CYCLE,
    parameter bit MULTI_WRITE = 1'b1,
    parameter bit BYPASS      = 1'b1,
    parameter int CNT_W       = 8,
    localparam int SEL_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CYCLE_W-1:0]         cycle,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_REGS-1:0]        wr_en,
    input  logic                       wr_flag_en,
    input  logic                       wr_flag,
    input  logic [SEL_W-1:0]           rd_sel,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       carry,
    output logic                       pending,
    output logic                       conflict,
    input  logic                       conflict_clr,
    output logic [CNT_W-1:0]           commit_cnt
);

    localparam int REQ_W = DATA_W + NUM_REGS + 2;

    logic                do_write;
    logic [REQ_W-1:0]    in_req;
    logic [REQ_W-1:0]    commit_req;
    logic                commit;
    logic [DATA_W-1:0]   c_data;
    logic [NUM_REGS-1:0] c_en;
    logic                c_flag_en;
    logic                c_flag;
    logic [NUM_REGS-1:0] wr_mask;
    logic                multi_hit;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              carry_q, carry_d;
    logic              conflict_q, conflict_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign do_write = (cycle == CYCLE_W'(WRITE_CYCLE));
    assign in_req   = {wr_data, wr_en, wr_flag_en, wr_flag};

    tb_wb_buffer #(
        .REQ_W (REQ_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .do_write   (do_write),
        .in_valid   (wr_valid),
        .in_ready   (wr_ready),
        .in_req     (in_req),
        .commit     (commit),
        .commit_req (commit_req),
        .pending    (pending)
    );

    assign c_data    = commit_req[REQ_W-1 -: DATA_W];
    assign c_en      = commit_req[NUM_REGS+1:2];
    assign c_flag_en = commit_req[1];
    assign c_flag    = commit_req[0];
    assign multi_hit = (c_en & (c_en - NUM_REGS'(1))) != '0;

    // Single-write mode keeps only the lowest set target (x & -x).
    always_comb begin
        wr_mask = '0;
        if (commit) begin
            if (MULTI_WRITE) begin
                wr_mask = c_en;
            end else begin
                wr_mask = c_en & (~c_en + NUM_REGS'(1));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = wr_mask[i] ? c_data : regs_q[i];
        end
        carry_d = (commit && c_flag_en) ? c_flag : carry_q;
        cnt_d   = commit ? cnt_q + CNT_W'(1) : cnt_q;
        if (commit && !MULTI_WRITE && multi_hit) begin
            conflict_d = 1'b1;
        end else if (conflict_clr) begin
            conflict_d = 1'b0;
        end else begin
            conflict_d = conflict_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            carry_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            carry_q    <= carry_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    // Out-of-range selects fall through the loop and read zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rd_sel) == i) begin
                rd_data = (BYPASS && wr_mask[i]) ? c_data : regs_q[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign carry      = carry_q;
    assign conflict   = conflict_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_tb_wb_regfile.sv
// Directed bench for tb_wb_regfile: a vector table for the handshake and
// commit timing, plus sequences for reset, conflict and counter wrap.
module tb_tb_wb_regfile;
    import tb_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cycle;
    logic        wr_valid;
    logic [3:0]  wr_data;
    logic [2:0]  wr_en;
    logic        wr_flag_en;
    logic        wr_flag;
    logic [1:0]  rd_sel;
    logic        conflict_clr;

    logic        a_ready, b_ready;
    logic [3:0]  a_rd, b_rd;
    logic [11:0] a_regs, b_regs;
    logic        a_carry, b_carry;
    logic        a_pend, b_pend;
    logic        a_conf, b_conf;
    logic [7:0]  a_cnt, b_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tb_wb_regfile #(.MULTI_WRITE(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .cycle(cycle), .wr_valid(wr_valid), .wr_ready(a_ready),
        .wr_data(wr_data), .wr_en(wr_en), .wr_flag_en(wr_flag_en), .wr_flag(wr_flag),
        .rd_sel(rd_sel), .rd_data(a_rd), .regs(a_regs), .carry(a_carry), .pending(a_pend),
        .conflict(a_conf), .conflict_clr(conflict_clr), .commit_cnt(a_cnt)
    );

    tb_wb_regfile #(.MULTI_WRITE(1'b0), .BYPASS(1'b0)) dut_mw0 (
        .clk(clk), .rst(rst), .cycle(cycle), .wr_valid(wr_valid), .wr_ready(b_ready),
        .wr_data(wr_data), .wr_en(wr_en), .wr_flag_en(wr_flag_en), .wr_flag(wr_flag),
        .rd_sel(rd_sel), .rd_data(b_rd), .regs(b_regs), .carry(b_carry), .pending(b_pend),
        .conflict(b_conf), .conflict_clr(conflict_clr), .commit_cnt(b_cnt)
    );

    typedef struct {
        logic [2:0]  cyc;
        logic        vld;
        wb_req_t     req;
        logic [1:0]  rsel;
        logic        exp_ready;
        logic [3:0]  exp_rd;
        logic        exp_pend;
        logic [11:0] exp_regs;
        logic        exp_carry;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] cyc, input logic vld, input logic [3:0] d,
                                input logic [2:0] en, input logic fe, input logic fl,
                                input logic [1:0] rs, input logic er, input logic [3:0] erd,
                                input logic ep, input logic [11:0] eregs, input logic ec,
                                input logic [7:0] ecnt);
        vec_t v;
        v.cyc = cyc; v.vld = vld; v.rsel = rs;
        v.req.data = d; v.req.en = en; v.req.flag_en = fe; v.req.flag = fl;
        v.exp_ready = er; v.exp_rd = erd; v.exp_pend = ep;
        v.exp_regs = eregs; v.exp_carry = ec; v.exp_cnt = ecnt;
        return v;
    endfunction

    initial begin
        // cyc vld data en fe fl rsel | ready rd | pend regs{r2,r1,r0} carry cnt
        vecs[0]  = mk(3'd2, 1, 4'hA, 3'b001, 0, 0, 2'd0, 1, 4'h0, 1, 12'h000, 0, 8'd0);
        vecs[1]  = mk(3'd3, 0, 4'h0, 3'b000, 0, 0, 2'd0, 0, 4'h0, 1, 12'h000, 0, 8'd0);
        vecs[2]  = mk(3'd4, 0, 4'h0, 3'b000, 0, 0, 2'd0, 0, 4'h0, 1, 12'h000, 0, 8'd0);
        vecs[3]  = mk(3'd5, 0, 4'h0, 3'b000, 0, 0, 2'd0, 0, 4'h0, 1, 12'h000, 0, 8'd0);
        vecs[4]  = mk(3'd6, 0, 4'h0, 3'b000, 0, 0, 2'd0, 1, 4'hA, 0, 12'h00A, 0, 8'd1);
        vecs[5]  = mk(3'd7, 0, 4'h0, 3'b000, 0, 0, 2'd0, 1, 4'hA, 0, 12'h00A, 0, 8'd1);
        vecs[6]  = mk(3'd6, 1, 4'h5, 3'b110, 1, 1, 2'd1, 1, 4'h5, 0, 12'h55A, 1, 8'd2);
        vecs[7]  = mk(3'd0, 0, 4'h0, 3'b000, 0, 0, 2'd2, 1, 4'h5, 0, 12'h55A, 1, 8'd2);
        vecs[8]  = mk(3'd1, 1, 4'h3, 3'b001, 0, 0, 2'd0, 1, 4'hA, 1, 12'h55A, 1, 8'd2);
        vecs[9]  = mk(3'd2, 1, 4'h7, 3'b010, 0, 0, 2'd1, 0, 4'h5, 1, 12'h55A, 1, 8'd2);
        vecs[10] = mk(3'd3, 1, 4'h7, 3'b010, 0, 0, 2'd1, 0, 4'h5, 1, 12'h55A, 1, 8'd2);
        vecs[11] = mk(3'd5, 1, 4'h7, 3'b010, 0, 0, 2'd1, 0, 4'h5, 1, 12'h55A, 1, 8'd2);
        vecs[12] = mk(3'd6, 1, 4'h7, 3'b010, 0, 0, 2'd0, 1, 4'h3, 1, 12'h553, 1, 8'd3);
        vecs[13] = mk(3'd7, 0, 4'h0, 3'b000, 0, 0, 2'd1, 0, 4'h5, 1, 12'h553, 1, 8'd3);
        vecs[14] = mk(3'd0, 0, 4'h0, 3'b000, 0, 0, 2'd3, 0, 4'h0, 1, 12'h553, 1, 8'd3);
        vecs[15] = mk(3'd6, 0, 4'h0, 3'b000, 0, 0, 2'd1, 1, 4'h7, 0, 12'h573, 1, 8'd4);
        vecs[16] = mk(3'd6, 1, 4'h9, 3'b000, 1, 0, 2'd0, 1, 4'h3, 0, 12'h573, 0, 8'd5);

        rst = 1'b1; cycle = 3'd0; wr_valid = 1'b0; wr_data = 4'h0; wr_en = 3'b000;
        wr_flag_en = 1'b0; wr_flag = 1'b0; rd_sel = 2'd0; conflict_clr = 1'b0;
        #12;
        check("rst_regs", a_regs, 12'h000);
        check("rst_carry", a_carry, 1'b0);
        check("rst_cnt", a_cnt, 8'd0);
        check("rst_pend", a_pend, 1'b0);
        check("rst_conf", a_conf, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready", a_ready, 1'b1);
        tick();

        for (int i = 0; i < 17; i++) begin
            cycle = vecs[i].cyc; wr_valid = vecs[i].vld; wr_data = vecs[i].req.data;
            wr_en = vecs[i].req.en; wr_flag_en = vecs[i].req.flag_en;
            wr_flag = vecs[i].req.flag; rd_sel = vecs[i].rsel;
            #4;
            check($sformatf("v%0d_ready", i), a_ready, vecs[i].exp_ready);
            check($sformatf("v%0d_rd", i), a_rd, vecs[i].exp_rd);
            tick();
            check($sformatf("v%0d_pend", i), a_pend, vecs[i].exp_pend);
            check($sformatf("v%0d_regs", i), a_regs, vecs[i].exp_regs);
            check($sformatf("v%0d_carry", i), a_carry, vecs[i].exp_carry);
            check($sformatf("v%0d_cnt", i), a_cnt, vecs[i].exp_cnt);
        end

        // Reset while a request is held, in the middle of a phase.
        cycle = 3'd3; wr_valid = 1'b1; wr_data = 4'hE; wr_en = 3'b100;
        wr_flag_en = 1'b1; wr_flag = 1'b1; rd_sel = 2'd2;
        tick();
        check("hold_pend", a_pend, 1'b1);
        wr_valid = 1'b0; cycle = 3'd4;
        #2;
        rst = 1'b1;
        #1;
        check("arst_regs", a_regs, 12'h000);
        check("arst_carry", a_carry, 1'b0);
        check("arst_cnt", a_cnt, 8'd0);
        check("arst_pend", a_pend, 1'b0);
        check("arst_conf_b", b_conf, 1'b0);
        tick();
        rst = 1'b0;
        cycle = 3'd5;
        tick();
        cycle = 3'd6;
        tick();
        check("drop_regs", a_regs, 12'h000);
        check("drop_cnt", a_cnt, 8'd0);
        check("drop_carry", a_carry, 1'b0);
        check("drop_pend", a_pend, 1'b0);

        // Multi-target commit on both instances.
        cycle = 3'd6; wr_valid = 1'b1; wr_data = 4'hC; wr_en = 3'b101;
        wr_flag_en = 1'b0; wr_flag = 1'b0; rd_sel = 2'd0;
        #4;
        check("byp_a_rd", a_rd, 4'hC);
        check("nobyp_b_rd", b_rd, 4'h0);
        tick();
        check("mw0_regs", b_regs, 12'h00C);
        check("mw0_conf", b_conf, 1'b1);
        check("mw1_regs", a_regs, 12'hC0C);
        check("mw1_conf", a_conf, 1'b0);
        wr_data = 4'h1; wr_en = 3'b011; conflict_clr = 1'b1;
        tick();
        check("setwins_conf", b_conf, 1'b1);
        check("setwins_regs", b_regs, 12'h001);
        check("mw1_regs2", a_regs, 12'hC11);
        cycle = 3'd0; wr_valid = 1'b0;
        tick();
        check("clr_conf", b_conf, 1'b0);
        check("cnt_before_wrap", a_cnt, 8'd2);
        conflict_clr = 1'b0;

        // Null commits every cycle until the counter wraps.
        cycle = 3'd6; wr_valid = 1'b1; wr_en = 3'b000; wr_flag_en = 1'b0; wr_data = 4'hF;
        for (int i = 0; i < 253; i++) begin
            tick();
        end
        check("cnt_max", a_cnt, 8'd255);
        tick();
        check("cnt_wrap", a_cnt, 8'd0);
        check("wrap_regs", a_regs, 12'hC11);
        check("wrap_carry", a_carry, 1'b0);
        wr_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tb_wb_regfile.md
Name: tb_wb_regfile

Overview:
- Parametrised register write-back unit for the miniTB-family CPU.
- Generalises the fixed A/B/OUT write-back to NUM_REGS registers of DATA_W bits, plus a carry flag.
- Write requests arrive through a valid/ready handshake at any cycle phase and are held in a single-entry pending buffer. They commit only in the WRITE_CYCLE phase.
- Adds a bypassed read port, a sticky conflict flag and a commit counter for debug.

Parameters:
- DATA_W, 4, register and data width
- NUM_REGS, 3, number of architectural registers (index 0..NUM_REGS-1)
- CYCLE_W, 3, width of the cycle phase input
- WRITE_CYCLE, 6, phase value in which commits occur
- MULTI_WRITE, 1, 1 = several wr_en bits may commit together; 0 = only the lowest set bit commits and conflict is flagged
- BYPASS, 1, 1 = rd_data forwards data committing this cycle
- CNT_W, 8, commit counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cycle  in  CYCLE_W  current CPU phase
- wr_valid  in  1  write request valid
- wr_ready  out  1  unit can accept a request
- wr_data  in  DATA_W  write data
- wr_en  in  NUM_REGS  one bit per target register
- wr_flag_en  in  1  request also writes the carry flag
- wr_flag  in  1  carry value
- rd_sel  in  clog2(NUM_REGS)  read select
- rd_data  out  DATA_W  read data
- regs  out  NUM_REGS*DATA_W  flat register view, reg i at bits [i*DATA_W +: DATA_W]
- carry  out  1  carry flag
- pending  out  1  buffer holds an uncommitted request
- conflict  out  1  sticky multi-target flag
- conflict_clr  in  1  clears conflict
- commit_cnt  out  CNT_W  number of commits, wrapping

Behaviour:
- Reset is asynchronous and active-high on rst; the clock is clk. All state is clocked on the rising edge of clk.
- Values while rst is high:
  - all registers 0, carry 0
  - pending 0 and buffer contents discarded
  - conflict 0, commit_cnt 0
  - wr_ready 1 after reset deassertion
- A reset in mid-operation drops any buffered request; it is never committed.
- doWrite is defined as (cycle == WRITE_CYCLE).
- Buffer states:
  - EMPTY: wr_ready = 1.
  - HELD: wr_ready = doWrite (the slot frees in the commit cycle).
- Accept happens when wr_valid && wr_ready.
- EMPTY, accept, doWrite: request commits directly in the same edge (zero-wait pass-through). State stays EMPTY.
- EMPTY, accept, !doWrite: request is latched and the state goes to HELD.
- HELD, doWrite: the held request commits.
  - With a simultaneous accept, the new request is latched and the state stays HELD. It commits at the next doWrite, never in the same edge.
  - Without an accept, the state goes to EMPTY.
- HELD, !doWrite: the buffer holds its contents and new requests stall.
- Commit:
  - For each target i selected by wr_en, reg[i] <= data.
  - If flag_en, carry <= flag.
  - commit_cnt increments by 1 per commit, wrapping from 2^CNT_W-1 to 0.
- A request with wr_en == 0 and flag_en == 0 still commits: nothing is written, but commit_cnt increments.
- With MULTI_WRITE = 0 and more than one wr_en bit set at commit: only the lowest index is written, and conflict is set. With MULTI_WRITE = 1, all selected registers are written and conflict is never set.
- conflict_clr clears conflict. If conflict_clr and a new conflict occur in the same cycle, set wins.
- rd_data is combinational from rd_sel. If BYPASS = 1 and a commit this cycle writes reg[rd_sel], rd_data = committing data; otherwise rd_data = the stored value.
- rd_sel >= NUM_REGS reads 0.
- pending = (state == HELD).

Decomposition:
- Shared package tb_cpu_pkg holds:
  - the phase constants (X2 = 3'd6 etc.)
  - the DATA_W default
  - a wb_req_t struct {data, en, flag_en, flag}
- One sub-module is natural: tb_wb_buffer. It is the single-entry valid/ready holding register with commit-timing control. The register array, bypass, conflict and counter logic stay in the top level.

Test Plan:
- Reset, then a request data = 4'hA, wr_en = 3'b001 at cycle = 2 -> pending = 1. Registers are unchanged until cycle = 6; at that edge reg0 = 4'hA, pending = 0, commit_cnt = 1.
- Request data = 4'h5, wr_en = 3'b110, flag_en = 1, flag = 1, presented at cycle = 6 with the buffer empty -> same-edge commit: reg1 = reg2 = 4'h5, carry = 1. rd_sel = 1 shows 4'h5 combinationally during that cycle (bypass).
- Buffer HELD with 4'h3 -> reg0; a second request 4'h7 -> reg1 is stalled until cycle = 6 (wr_ready = 0 at phases 0-5). At cycle = 6, reg0 = 4'h3 commits and 4'h7 is latched. reg1 = 4'h7 only at the next cycle = 6.
- MULTI_WRITE = 0, wr_en = 3'b101, data 4'hC -> only reg0 = 4'hC, reg2 unchanged, conflict = 1. conflict_clr pulse -> conflict = 0.
- Assert rst while HELD, mid-phase -> all registers, carry, commit_cnt = 0 and pending = 0. The dropped request never appears after the next cycle = 6.
- 256 null commits with CNT_W = 8 -> commit_cnt wraps to 0; registers unchanged.
